// File: rtl/timer_sched.sv
// timer_sched: round-robin scheduler sharing one external timer among four requesters.
// A request is granted in IDLE. The winner's period is loaded into the timer and a
// start pulse is issued. The block then waits for the timer to expire and pulses
// done back to the winner.
//
// Ports:
//   CLK        - clock, rising edge
//   RST        - asynchronous active-low reset (also resets the external timer)
//   req        - level request per requester, held until its done is seen
//   period_bus - per-requester 8-bit period, requester i at [8i+7:8i]
//   grant      - one-hot owner of the timer, zero when idle
//   done       - one-cycle completion pulse to the owner
//   busy       - high whenever the FSM is not idle
//   tmr_circle - period driven into the timer
//   tmr_start  - timer start strobe
//   tmr_over   - timer expiry from the timer
module timer_sched (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  req,
   input  logic [31:0] period_bus,
   output logic [3:0]  grant,
   output logic [3:0]  done,
   output logic        busy,
   output logic [7:0]  tmr_circle,
   output logic        tmr_start,
   input  logic        tmr_over
);

   typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

   state_e     state_q, state_d;
   logic [3:0] grant_q, grant_d;
   logic [7:0] circle_q, circle_d;
   logic [1:0] ptr_q, ptr_d;

   logic       win_found;
   logic [1:0] win_idx;
   logic [1:0] arb_idx;
   logic [7:0] win_period;
   logic [1:0] grant_idx;

   // Round-robin search starting just after the last winner, wrapping over all four.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 2'd0;
      arb_idx   = 2'd0;
      for (int unsigned off = 1; off <= 4; off++) begin
         arb_idx = ptr_q + 2'(off);
         if (!win_found && req[arb_idx]) begin
            win_found = 1'b1;
            win_idx   = arb_idx;
         end
      end
   end

   assign win_period = period_bus[{win_idx, 3'b000} +: 8];

   always_comb begin
      grant_idx = 2'd0;
      case (grant_q)
         4'b0010: grant_idx = 2'd1;
         4'b0100: grant_idx = 2'd2;
         4'b1000: grant_idx = 2'd3;
         default: grant_idx = 2'd0;
      endcase
   end

   // Arbitration happens only in IDLE: the winner still holds req while it sees done,
   // so arbitrating in DONE would re-grant a requester that is about to drop.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      circle_d = circle_q;
      ptr_d    = ptr_q;
      case (state_q)
         StIdle: begin
            if (win_found) begin
               grant_d  = 4'b0001 << win_idx;
               circle_d = win_period;
               // A zero load never expires in the timer, so skip straight to DONE.
               state_d  = (win_period != 8'h00) ? StStart : StDone;
            end
         end
         StStart: state_d = StWait;
         StWait: begin
            if (tmr_over) begin
               state_d = StDone;
            end
         end
         StDone: begin
            ptr_d   = grant_idx;
            grant_d = 4'b0000;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= StIdle;
         grant_q  <= 4'b0000;
         circle_q <= 8'h00;
         ptr_q    <= 2'd3;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         circle_q <= circle_d;
         ptr_q    <= ptr_d;
      end
   end

   assign grant      = grant_q;
   assign tmr_circle = circle_q;
   assign busy       = (state_q != StIdle);
   assign tmr_start  = (state_q == StStart);
   assign done       = (state_q == StDone) ? grant_q : 4'b0000;

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched with a small behavioural model of the shared timer.
module tb_timer_sched;

   logic        CLK;
   logic        RST;
   logic [3:0]  req;
   logic [31:0] period_bus;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        busy;
   logic [7:0]  tmr_circle;
   logic        tmr_start;
   logic        tmr_over;

   logic        force_over;
   logic        model_over;
   logic        model_run;
   logic [7:0]  model_cnt;

   int n_pass;
   int n_total;
   int lat;
   int lat2;
   int starts;
   logic [3:0] dval;

   timer_sched dut (
      .CLK        (CLK),
      .RST        (RST),
      .req        (req),
      .period_bus (period_bus),
      .grant      (grant),
      .done       (done),
      .busy       (busy),
      .tmr_circle (tmr_circle),
      .tmr_start  (tmr_start),
      .tmr_over   (tmr_over)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Timer: loads on the start strobe, raises over for one cycle P edges after loading.
   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         model_cnt  <= 8'h00;
         model_run  <= 1'b0;
         model_over <= 1'b0;
      end else if (tmr_start) begin
         model_cnt  <= tmr_circle;
         model_run  <= (tmr_circle != 8'h00);
         model_over <= 1'b0;
      end else if (model_run) begin
         if (model_cnt == 8'd1) begin
            model_over <= 1'b1;
            model_run  <= 1'b0;
         end
         model_cnt <= model_cnt - 8'd1;
      end else begin
         model_over <= 1'b0;
      end
   end

   assign tmr_over = model_over | force_over;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Called just after the grant edge; steps until done is seen or the bound expires.
   task automatic wait_done(input int bound, output int l, output logic [3:0] dv,
                            output int st);
      st = int'(tmr_start);
      l  = -1;
      dv = 4'b0000;
      for (int j = 1; j <= bound; j++) begin
         step();
         st += int'(tmr_start);
         if (done != 4'b0000) begin
            l  = j;
            dv = done;
            break;
         end
      end
   endtask

   task automatic do_reset();
      RST = 1'b0;
      #2;
      RST = 1'b1;
   endtask

   initial begin
      n_pass     = 0;
      n_total    = 0;
      RST        = 1'b0;
      req        = 4'b0000;
      period_bus = 32'h0;
      force_over = 1'b0;

      // Reset values
      #12;
      chk("rst grant", 32'(grant), 32'h0);
      chk("rst done", 32'(done), 32'h0);
      chk("rst busy", 32'(busy), 32'h0);
      chk("rst start", 32'(tmr_start), 32'h0);
      chk("rst circle", 32'(tmr_circle), 32'h0);
      step();
      RST = 1'b1;
      step();

      // Single request, P=5
      period_bus[7:0] = 8'd5;
      req = 4'b0001;
      step();
      chk("single grant", 32'(grant), 32'h1);
      chk("single circle", 32'(tmr_circle), 32'd5);
      chk("single start", 32'(tmr_start), 32'h1);
      chk("single busy", 32'(busy), 32'h1);
      wait_done(40, lat, dval, starts);
      chk("single latency", 32'(lat), 32'd7);
      chk("single done", 32'(dval), 32'h1);
      chk("single starts", 32'(starts), 32'd1);
      req = 4'b0000;
      step();
      chk("single busy fall", 32'(busy), 32'h0);
      chk("single grant clr", 32'(grant), 32'h0);

      // Round-robin with all four requesting; periods 2/3/4/1
      step();
      do_reset();
      period_bus = {8'd1, 8'd4, 8'd3, 8'd2};
      req = 4'b1111;
      step();
      for (int n = 0; n < 5; n++) begin
         int exp_idx;
         int p;
         exp_idx = n % 4;
         p = (exp_idx == 0) ? 2 : (exp_idx == 1) ? 3 : (exp_idx == 2) ? 4 : 1;
         chk("rr grant", 32'(grant), 32'(4'b0001 << exp_idx));
         wait_done(40, lat, dval, starts);
         chk("rr latency", 32'(lat), 32'(p + 2));
         chk("rr done", 32'(dval), 32'(4'b0001 << exp_idx));
         if (n == 4) begin
            req = 4'b0000;
         end
         step();
         chk("rr idle gap", 32'(busy), 32'h0);
         step();
      end

      // Zero period on requester 2
      period_bus = 32'h0;
      req = 4'b0100;
      step();
      chk("zero grant", 32'(grant), 32'h4);
      chk("zero start", 32'(tmr_start), 32'h0);
      chk("zero done", 32'(done), 32'h4);
      req = 4'b0000;
      step();
      chk("zero idle", 32'(busy), 32'h0);
      chk("zero start2", 32'(tmr_start), 32'h0);

      // Period change and request drop during WAIT, requester 1 with P=10
      period_bus[15:8] = 8'd10;
      req = 4'b0010;
      step();
      chk("chg grant", 32'(grant), 32'h2);
      chk("chg circle", 32'(tmr_circle), 32'd10);
      step();
      step();
      step();
      period_bus[15:8] = 8'd3;
      req = 4'b0000;
      wait_done(40, lat2, dval, starts);
      chk("chg latency", 32'(lat2 + 3), 32'd12);
      chk("chg done", 32'(dval), 32'h2);
      chk("chg circle hold", 32'(tmr_circle), 32'd10);
      step();
      chk("chg idle", 32'(busy), 32'h0);

      // Asynchronous reset in WAIT
      period_bus[31:24] = 8'd20;
      req = 4'b1000;
      step();
      chk("ar grant", 32'(grant), 32'h8);
      step();
      step();
      step();
      #2;
      RST = 1'b0;
      #1;
      chk("ar grant", 32'(grant), 32'h0);
      chk("ar busy", 32'(busy), 32'h0);
      chk("ar done", 32'(done), 32'h0);
      chk("ar start", 32'(tmr_start), 32'h0);
      chk("ar circle", 32'(tmr_circle), 32'h0);
      RST = 1'b1;
      period_bus[31:24] = 8'd4;
      step();
      chk("ar2 grant", 32'(grant), 32'h8);
      chk("ar2 circle", 32'(tmr_circle), 32'd4);
      wait_done(40, lat, dval, starts);
      chk("ar2 latency", 32'(lat), 32'd6);
      chk("ar2 done", 32'(dval), 32'h8);
      chk("ar2 starts", 32'(starts), 32'd1);
      req = 4'b0000;
      step();
      chk("ar2 idle", 32'(busy), 32'h0);

      // Spurious tmr_over in IDLE
      force_over = 1'b1;
      for (int j = 0; j < 3; j++) begin
         step();
         chk("spur busy", 32'(busy), 32'h0);
         chk("spur done", 32'(done), 32'h0);
      end
      force_over = 1'b0;

      // tmr_over during START is ignored
      period_bus[7:0] = 8'd3;
      req = 4'b0001;
      step();
      chk("ostart grant", 32'(grant), 32'h1);
      force_over = 1'b1;
      step();
      force_over = 1'b0;
      chk("ostart busy", 32'(busy), 32'h1);
      chk("ostart done", 32'(done), 32'h0);
      wait_done(40, lat, dval, starts);
      chk("ostart latency", 32'(lat), 32'd4);
      chk("ostart done2", 32'(dval), 32'h1);
      req = 4'b0000;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
